// File: rtl/acs_pm_unit.sv
// acs_pm_unit
// Add-compare-select stage of the Viterbi decoder. For every accepted trellis
// step it adds the branch distances to the stored path metrics. For each next
// state it picks the cheapest of the four predecessors. It then normalizes all
// metrics against the step minimum and registers them. The per-state 2-bit
// survivor decisions go to the traceback stage.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_start        begin a frame: load initial metrics, latch i_frame_len
//   i_frame_len    number of trellis steps in the frame
//   i_valid        i_dist carries one trellis step
//   i_dist         branch distance per current state s and input symbol u
//   o_busy         high while a frame is running
//   o_dec_valid    one-cycle strobe: o_dec/o_best_state/o_min_raw updated
//   o_dec          winning predecessor index p per next state
//   o_best_state   lowest-index state whose normalized metric is 0
//   o_min_raw      minimum pre-normalization metric of the last step
//   o_step_cnt     steps accepted in the current frame
//   o_done         one-cycle pulse at frame end
module acs_pm_unit #(
  parameter int STATE_W = 8,
  parameter int RADIX   = 4,
  parameter int BM_W    = 3,
  parameter int PM_W    = 8,
  parameter int INIT_PM = 32,
  localparam int STATE_NUM = 2 ** STATE_W
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         i_start,
  input  logic [15:0]                                  i_frame_len,
  input  logic                                         i_valid,
  input  logic [STATE_NUM-1:0][RADIX-1:0][BM_W-1:0]    i_dist,
  output logic                                         o_busy,
  output logic                                         o_dec_valid,
  output logic [STATE_NUM-1:0][1:0]                    o_dec,
  output logic [STATE_W-1:0]                           o_best_state,
  output logic [PM_W-1:0]                              o_min_raw,
  output logic [15:0]                                  o_step_cnt,
  output logic                                         o_done
);

  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                             state;
  logic [15:0]                        frame_len;
  logic [STATE_NUM-1:0][PM_W-1:0]     pm;

  logic [STATE_NUM-1:0][PM_W:0]       raw;
  logic [STATE_NUM-1:0][1:0]          sel;
  logic [STATE_NUM-1:0][PM_W-1:0]     pm_next;
  logic [PM_W:0]                      min_raw;
  logic [STATE_W-1:0]                 best_state;
  logic [PM_W-1:0]                    min_sat;

  // Add-compare-select plus normalization. Predecessors of ns share the
  // low bits ns>>2 and differ only in the top two bits, which is p. All sums
  // carry one extra bit so that they cannot wrap before normalization.
  always_comb begin
    logic [STATE_W-1:0] sp;
    logic [1:0]         u;
    logic [PM_W:0]      cand;
    logic [PM_W:0]      diff;
    sp         = '0;
    u          = '0;
    cand       = '0;
    diff       = '0;
    raw        = '0;
    sel        = '0;
    pm_next    = '0;
    min_raw    = '0;
    best_state = '0;
    min_sat    = '0;

    for (int ns = 0; ns < STATE_NUM; ns++) begin
      u = ns[1:0];
      for (int p = 0; p < RADIX; p++) begin
        sp   = STATE_W'((ns >> 2) | (p << (STATE_W - 2)));
        cand = {1'b0, pm[sp]} + (PM_W + 1)'(i_dist[sp][u]);
        // Strict compare keeps the lowest p on ties.
        if (p == 0 || cand < raw[ns]) begin
          raw[ns] = cand;
          sel[ns] = 2'(p);
        end
      end
    end

    // Strict compare keeps the lowest-index state on ties.
    min_raw = raw[0];
    for (int ns = 1; ns < STATE_NUM; ns++) begin
      if (raw[ns] < min_raw) begin
        min_raw    = raw[ns];
        best_state = STATE_W'(ns);
      end
    end

    for (int ns = 0; ns < STATE_NUM; ns++) begin
      diff        = raw[ns] - min_raw;
      pm_next[ns] = (diff > PM_MAX) ? {PM_W{1'b1}} : diff[PM_W-1:0];
    end
    min_sat = (min_raw > PM_MAX) ? {PM_W{1'b1}} : min_raw[PM_W-1:0];
  end

  // Frame control and metric storage. i_start takes priority in every state,
  // so a step that arrives together with a restart is dropped. o_done is set
  // on the edge that enters DONE and cleared on the edge that leaves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame_len    <= '0;
      pm           <= '0;
      o_busy       <= 1'b0;
      o_dec_valid  <= 1'b0;
      o_dec        <= '0;
      o_best_state <= '0;
      o_min_raw    <= '0;
      o_step_cnt   <= '0;
      o_done       <= 1'b0;
    end else begin
      o_dec_valid <= 1'b0;
      o_done      <= 1'b0;
      if (i_start) begin
        for (int i = 0; i < STATE_NUM; i++) begin
          pm[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
        end
        frame_len  <= i_frame_len;
        o_step_cnt <= '0;
        if (i_frame_len == 16'd0) begin
          state  <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end else begin
          state  <= RUN;
          o_busy <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (i_valid) begin
              pm           <= pm_next;
              o_dec        <= sel;
              o_best_state <= best_state;
              o_min_raw    <= min_sat;
              o_dec_valid  <= 1'b1;
              o_step_cnt   <= o_step_cnt + 16'd1;
              if (o_step_cnt + 16'd1 == frame_len) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acs_pm_unit.sv
// tb_acs_pm_unit
// Directed bench for acs_pm_unit with STATE_W=2, PM_W=8, INIT_PM=32. Inputs are
// driven on the falling edge, and outputs are sampled on the next falling edge.
// Path metrics are observed through the instance's internal pm register,
// packed with state 0 in the low byte.
module tb_acs_pm_unit;

  logic                    clk;
  logic                    rst;
  logic                    i_start;
  logic [15:0]             i_frame_len;
  logic                    i_valid;
  logic [3:0][3:0][2:0]    i_dist;
  logic                    o_busy;
  logic                    o_dec_valid;
  logic [3:0][1:0]         o_dec;
  logic [1:0]              o_best_state;
  logic [7:0]              o_min_raw;
  logic [15:0]             o_step_cnt;
  logic                    o_done;

  int total;
  int bad;

  acs_pm_unit #(
    .STATE_W(2), .RADIX(4), .BM_W(3), .PM_W(8), .INIT_PM(32)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_frame_len(i_frame_len),
    .i_valid(i_valid), .i_dist(i_dist), .o_busy(o_busy),
    .o_dec_valid(o_dec_valid), .o_dec(o_dec), .o_best_state(o_best_state),
    .o_min_raw(o_min_raw), .o_step_cnt(o_step_cnt), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", o_busy); end
    total++; if (o_dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dec_valid got=%b exp=0", o_dec_valid); end
    total++; if (o_dec !== 8'h00) begin bad++; $display("[TB] FAIL reset_dec got=%h exp=00", o_dec); end
    total++; if (o_step_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_step got=%0d exp=0", o_step_cnt); end
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", o_done); end
    total++; if (dut.pm !== 32'h0) begin bad++; $display("[TB] FAIL reset_pm got=%h exp=00000000", dut.pm); end
    rst = 1'b0;
  endtask

  task automatic test_first_step;
    i_start = 1'b1; i_frame_len = 16'd4;
    @(negedge clk);
    i_start = 1'b0;
    total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL start_busy got=%b exp=1", o_busy); end
    total++; if (dut.pm !== 32'h20202000) begin bad++; $display("[TB] FAIL start_pm got=%h exp=20202000", dut.pm); end
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 4; u++)
        i_dist[s][u] = (s == 0) ? 3'd1 : 3'd3;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_dec_valid !== 1'b1) begin bad++; $display("[TB] FAIL s1_dec_valid got=%b exp=1", o_dec_valid); end
    total++; if (o_dec !== 8'h00) begin bad++; $display("[TB] FAIL s1_dec got=%h exp=00", o_dec); end
    total++; if (dut.pm !== 32'h0) begin bad++; $display("[TB] FAIL s1_pm got=%h exp=00000000", dut.pm); end
    total++; if (o_min_raw !== 8'd1) begin bad++; $display("[TB] FAIL s1_min_raw got=%0d exp=1", o_min_raw); end
    total++; if (o_best_state !== 2'd0) begin bad++; $display("[TB] FAIL s1_best got=%0d exp=0", o_best_state); end
    total++; if (o_step_cnt !== 16'd1) begin bad++; $display("[TB] FAIL s1_step got=%0d exp=1", o_step_cnt); end
  endtask

  task automatic test_tie_step;
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 4; u++)
        i_dist[s][u] = 3'(u);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (dut.pm !== 32'h03020100) begin bad++; $display("[TB] FAIL tie_pm got=%h exp=03020100", dut.pm); end
    total++; if (o_dec !== 8'h00) begin bad++; $display("[TB] FAIL tie_dec got=%h exp=00", o_dec); end
    total++; if (o_min_raw !== 8'd0) begin bad++; $display("[TB] FAIL tie_min_raw got=%0d exp=0", o_min_raw); end
    total++; if (o_best_state !== 2'd0) begin bad++; $display("[TB] FAIL tie_best got=%0d exp=0", o_best_state); end
    @(negedge clk);
    total++; if (o_dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_dec_valid got=%b exp=0", o_dec_valid); end
    total++; if (o_step_cnt !== 16'd2) begin bad++; $display("[TB] FAIL hold_step got=%0d exp=2", o_step_cnt); end
  endtask

  // PM=[0,1,2,3]; only dist[3][2]=0, all else 7. ns=2 picks p=3 (raw 3),
  // others pick p=0 (raw 7). Min 3 at state 2 -> PM=[4,4,0,4].
  task automatic test_select_step;
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 4; u++)
        i_dist[s][u] = (s == 3 && u == 2) ? 3'd0 : 3'd7;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_dec !== 8'h30) begin bad++; $display("[TB] FAIL sel_dec got=%h exp=30", o_dec); end
    total++; if (dut.pm !== 32'h04000404) begin bad++; $display("[TB] FAIL sel_pm got=%h exp=04000404", dut.pm); end
    total++; if (o_min_raw !== 8'd3) begin bad++; $display("[TB] FAIL sel_min_raw got=%0d exp=3", o_min_raw); end
    total++; if (o_best_state !== 2'd2) begin bad++; $display("[TB] FAIL sel_best got=%0d exp=2", o_best_state); end
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL sel_done got=%b exp=0", o_done); end
  endtask

  // Zero distances from PM=[4,4,0,4]: every ns picks p=2.
  task automatic test_frame_end;
    i_dist = '0;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_dec !== 8'hAA) begin bad++; $display("[TB] FAIL end_dec got=%h exp=aa", o_dec); end
    total++; if (dut.pm !== 32'h0) begin bad++; $display("[TB] FAIL end_pm got=%h exp=00000000", dut.pm); end
    total++; if (o_step_cnt !== 16'd4) begin bad++; $display("[TB] FAIL end_step got=%0d exp=4", o_step_cnt); end
    total++; if (o_done !== 1'b1) begin bad++; $display("[TB] FAIL end_done got=%b exp=1", o_done); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL end_busy got=%b exp=0", o_busy); end
    @(negedge clk);
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL end_done_clear got=%b exp=0", o_done); end
  endtask

  task automatic test_gapped_frame;
    i_dist = '0;
    i_start = 1'b1; i_frame_len = 16'd3;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_dec_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap1_dec_valid got=%b exp=1", o_dec_valid); end
    total++; if (o_step_cnt !== 16'd1) begin bad++; $display("[TB] FAIL gap1_step got=%0d exp=1", o_step_cnt); end
    @(negedge clk);
    total++; if (o_dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL gap1_idle got=%b exp=0", o_dec_valid); end
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_step_cnt !== 16'd2) begin bad++; $display("[TB] FAIL gap2_step got=%0d exp=2", o_step_cnt); end
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL gap2_done got=%b exp=0", o_done); end
    @(negedge clk);
    total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL gap2_busy got=%b exp=1", o_busy); end
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_dec_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap3_dec_valid got=%b exp=1", o_dec_valid); end
    total++; if (o_done !== 1'b1) begin bad++; $display("[TB] FAIL gap3_done got=%b exp=1", o_done); end
    total++; if (o_step_cnt !== 16'd3) begin bad++; $display("[TB] FAIL gap3_step got=%0d exp=3", o_step_cnt); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL gap3_busy got=%b exp=0", o_busy); end
    @(negedge clk);
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL gap_done_once got=%b exp=0", o_done); end
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL gap_ignore_valid got=%b exp=0", o_dec_valid); end
    total++; if (o_step_cnt !== 16'd3) begin bad++; $display("[TB] FAIL gap_ignore_step got=%0d exp=3", o_step_cnt); end
  endtask

  task automatic test_zero_len;
    i_start = 1'b1; i_frame_len = 16'd0;
    @(negedge clk);
    i_start = 1'b0;
    total++; if (o_done !== 1'b1) begin bad++; $display("[TB] FAIL zero_done got=%b exp=1", o_done); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy got=%b exp=0", o_busy); end
    total++; if (o_dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL zero_dec_valid got=%b exp=0", o_dec_valid); end
    @(negedge clk);
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL zero_done_clear got=%b exp=0", o_done); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy_after got=%b exp=0", o_busy); end
  endtask

  task automatic test_back_to_back;
    i_dist = '0;
    i_start = 1'b1; i_frame_len = 16'd4;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    total++; if (o_step_cnt !== 16'd1) begin bad++; $display("[TB] FAIL b2b_step1 got=%0d exp=1", o_step_cnt); end
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 4; u++)
        i_dist[s][u] = 3'd5;
    i_start = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b0;
    total++; if (dut.pm !== 32'h20202000) begin bad++; $display("[TB] FAIL b2b_pm got=%h exp=20202000", dut.pm); end
    total++; if (o_step_cnt !== 16'd0) begin bad++; $display("[TB] FAIL b2b_step got=%0d exp=0", o_step_cnt); end
    total++; if (o_dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_dec_valid got=%b exp=0", o_dec_valid); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b exp=1", o_busy); end
  endtask

  task automatic test_reset_mid_run;
    i_dist = '0;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_dec_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_dec_valid got=%b exp=1", o_dec_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b exp=0", o_busy); end
    total++; if (o_dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_dec_valid got=%b exp=0", o_dec_valid); end
    total++; if (o_step_cnt !== 16'd0) begin bad++; $display("[TB] FAIL mid_step got=%0d exp=0", o_step_cnt); end
    total++; if (dut.pm !== 32'h0) begin bad++; $display("[TB] FAIL mid_pm got=%h exp=00000000", dut.pm); end
    @(negedge clk);
    rst = 1'b0;
    i_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_done cycle=%0d got=%b exp=0", c, o_done); end
      total++; if (o_step_cnt !== 16'd0) begin bad++; $display("[TB] FAIL mid_idle_step cycle=%0d got=%0d exp=0", c, o_step_cnt); end
    end
    i_valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; i_start = 1'b0; i_frame_len = '0; i_valid = 1'b0; i_dist = '0;
    test_reset();
    test_first_step();
    test_tie_step();
    test_select_step();
    test_frame_end();
    test_gapped_frame();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acs_pm_unit.md
Name: acs_pm_unit

Overview:
- Add-compare-select stage of the Viterbi decoder, directly downstream of the branch metric unit.
- Each accepted trellis step combines the branch distances from the branch metric unit (indexed by current state and 2-bit input symbol) with stored path metrics.
- Per next-state it selects the best predecessor, normalizes, and registers the new path metrics.
- Emits per-state 2-bit survivor decisions to the traceback stage and tracks frame progress.

Parameters:
STATE_W, 8, state index width; STATE_NUM = 2**STATE_W (STATE_W >= 2)
RADIX, 4, branches per state (fixed, 2 input bits per step)
BM_W, 3, branch distance width
PM_W, 8, path metric width
INIT_PM, 32, initial metric of every state except state 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_start  in  1  begin frame: load initial metrics, latch i_frame_len
i_frame_len  in  16  number of trellis steps in frame
i_valid  in  1  i_dist valid for one trellis step
i_dist  in  BM_W x [STATE_NUM][RADIX]  branch distance per current state s, input u
o_busy  out  1  high in RUN
o_dec_valid  out  1  one-cycle strobe, o_dec/o_best_state/o_min_raw updated
o_dec  out  2 x [STATE_NUM]  winning predecessor index p per next state
o_best_state  out  STATE_W  lowest-index state with normalized metric 0
o_min_raw  out  PM_W  minimum pre-normalization metric of last step
o_step_cnt  out  16  steps accepted this frame
o_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all PMs=0; all outputs 0.
- Trellis: next state ns = ((s<<2)|u) mod STATE_NUM. Predecessors of ns are s_p = (ns>>2) | (p<<(STATE_W-2)), p=0..3, with u = ns[1:0].
- Candidate cand_p = PM[s_p] + i_dist[s_p][u], computed at PM_W+1 bits.
- Select: minimum cand_p; ties go to lowest p; o_dec[ns]=p.
- Normalize: raw[ns] = selected cand; m = min over all ns of raw; PM[ns] = raw[ns]-m, saturated to 2**PM_W-1. o_min_raw = m, saturated to PM_W.
- FSM states IDLE, RUN, DONE.
  - IDLE: i_valid ignored. i_start loads PM[0]=0, PM[others]=INIT_PM, latches i_frame_len, clears o_step_cnt, and goes to RUN on the same edge. If i_frame_len==0, go to DONE instead.
  - RUN: each clock with i_valid=1 is one step. PM, o_dec, o_best_state and o_min_raw register on that edge, and o_dec_valid=1 in the following cycle (1-cycle latency). o_step_cnt increments. i_valid=0 holds everything and o_dec_valid=0. When the increment makes o_step_cnt equal the latched length, go to DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE. PMs and o_step_cnt are retained until the next i_start.
- i_start in RUN or DONE restarts the frame (re-init, recount); a simultaneous i_valid is discarded.
- Reset mid-frame: immediate return to reset values; no o_done.
- o_busy=1 only in RUN.

Test Plan:
Bench instance: STATE_W=2, PM_W=8, INIT_PM=32.
1. i_start, i_frame_len=4; step with i_dist[0][u]=1, all others 3 -> next cycle o_dec_valid=1, o_dec all 0, all PM=0, o_min_raw=1, o_best_state=0, o_step_cnt=1.
2. Following step i_dist[s][u]=u for all s -> PM=[0,1,2,3], o_dec all 0 (tie lowest p), o_min_raw=0, o_best_state=0.
3. i_frame_len=3, three i_valid pulses separated by idle cycles -> o_dec_valid only after accepted steps; o_done pulses once, the cycle after the 3rd step's decision edge; o_step_cnt=3; o_busy then 0; further i_valid ignored.
4. i_start with i_frame_len=0 -> o_done pulse next cycle, no o_dec_valid, o_busy never 1.
5. Assert i_start together with i_valid at step 2 of a frame -> PM=[0,32,32,32], o_step_cnt=0, no o_dec_valid for that cycle.
6. Assert rst mid-RUN -> all outputs 0 immediately (async), FSM IDLE, no o_done after release.
